// File: rtl/bit_deserializer.sv
// bit_deserializer
// ----------------
// Receives a serial bit stream one bit per cycle over a valid/ready input and
// packs it into WIDTH-bit words. Each word is presented on a valid/ready
// output through a single registered holding stage. An in_last marker closes
// a partial word early, so framing can be exercised as well as plain words.
//
// Ports:
//   clk        clock; all logic updates on its rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_bit / in_last are valid this cycle
//   in_ready   block accepts a bit this cycle (combinational)
//   in_bit     serial data bit
//   in_last    this bit closes the current word / frame
//   out_valid  out_data / out_bits / out_last hold a word
//   out_ready  consumer takes the word this cycle
//   out_data   assembled word, right-justified
//   out_bits   number of valid bits in out_data (1..WIDTH)
//   out_last   word was closed by in_last
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_bits,
  output logic             out_last
);

  // The top bit of a word is only ever supplied directly by the completing
  // bit, so the partial-word register needs just WIDTH-1 bits.
  logic [WIDTH-2:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CW-1:0]    out_bits_q;
  logic             out_last_q;

  logic             accept;
  logic             cnt_at_top;
  logic             word_done;
  logic [WIDTH-1:0] word_d;   // partial word with the current bit merged in

  // The holding stage can take a new word when empty or draining this cycle.
  assign in_ready   = rst_n && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign cnt_at_top = (cnt_q == CW'(WIDTH - 1));
  assign word_done  = accept && (cnt_at_top || in_last);

  generate
    if (MSB_FIRST) begin : g_msb
      // Shifting left keeps the first bit at position n-1 for any word
      // length n, so the result is right-justified without a final shift.
      assign word_d = {shift_q, in_bit};
    end else begin : g_lsb
      // Each bit lands at its own index; untouched upper bits stay zero.
      genvar gi;
      for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
        assign word_d[gi] = (cnt_q == CW'(gi)) ? in_bit : shift_q[gi];
      end
      assign word_d[WIDTH-1] = cnt_at_top & in_bit;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bits_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        if (word_done) begin
          shift_q     <= '0;
          cnt_q       <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= word_d;
          out_bits_q  <= cnt_q + CW'(1);
          out_last_q  <= in_last;
        end else begin
          shift_q <= word_d[WIDTH-2:0];
          cnt_q   <= cnt_q + CW'(1);
        end
      end
      // A word completing in the drain cycle reloads the stage with no bubble.
      if (out_valid_q && out_ready && !word_done) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bits  = out_bits_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Directed testbench for bit_deserializer. Two instances (MSB-first and
// LSB-first, WIDTH=8) share one stimulus stream; expected values are
// hand-computed constants.
module tb_bit_deserializer;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_bit;
  logic             in_last;
  logic             out_ready;

  logic             m_in_ready, m_out_valid, m_out_last;
  logic [WIDTH-1:0] m_out_data;
  logic [CW-1:0]    m_out_bits;
  logic             l_in_ready, l_out_valid, l_out_last;
  logic [WIDTH-1:0] l_out_data;
  logic [CW-1:0]    l_out_bits;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bit_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_bit(in_bit), .in_last(in_last), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_data(m_out_data), .out_bits(m_out_bits),
    .out_last(m_out_last)
  );

  bit_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_bit(in_bit), .in_last(in_last), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_data(l_out_data), .out_bits(l_out_bits),
    .out_last(l_out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %-24s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic last);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send(v[i], 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    // Reset state
    check("rst_out_valid", m_out_valid, 0);
    check("rst_out_data",  m_out_data, 0);
    check("rst_out_bits",  m_out_bits, 0);
    check("rst_out_last",  m_out_last, 0);
    check("rst_in_ready",  m_in_ready, 0);

    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    check("in_ready_after_rst", m_in_ready, 1);

    // 1,1,0,0,0,0,0,0 -> MSB 0xC0, LSB 0x03
    send(1, 0); send(1, 0);
    for (int i = 0; i < 5; i++) send(0, 0);
    check("c0_not_yet_valid", m_out_valid, 0);
    send(0, 0);
    check("c0_valid",  m_out_valid, 1);
    check("c0_m_data", m_out_data, 8'hC0);
    check("c0_m_bits", m_out_bits, 8);
    check("c0_m_last", m_out_last, 0);
    check("c0_l_data", l_out_data, 8'h03);
    check("c0_l_bits", l_out_bits, 8);
    tick();
    check("c0_drained", m_out_valid, 0);

    // 1,0,1 with in_last on third -> 0x05, 3 bits, last
    send(1, 0); send(0, 0); send(1, 1);
    check("last3_valid",  m_out_valid, 1);
    check("last3_m_data", m_out_data, 8'h05);
    check("last3_m_bits", m_out_bits, 3);
    check("last3_m_last", m_out_last, 1);
    check("last3_l_data", l_out_data, 8'h05);
    tick();
    check("last3_drained", m_out_valid, 0);

    // Continuous 0xA5 then 0x3C; in_ready must stay high throughout
    for (int w = 0; w < 2; w++) begin
      logic [7:0] v;
      v = (w == 0) ? 8'hA5 : 8'h3C;
      for (int i = 7; i >= 0; i--) begin
        in_valid = 1'b1; in_bit = v[i]; #1;
        check("stream_in_ready", m_in_ready, 1);
        tick();
        if (i == 7 && w == 1) check("stream_gap_valid", m_out_valid, 0);
      end
      in_valid = 1'b0;
      check("stream_valid",  m_out_valid, 1);
      check("stream_m_data", m_out_data, v);
      check("stream_l_data", l_out_data, v);
    end
    tick();

    // Two 1-bit words back to back: stage reloads without a bubble
    send(1, 1);
    check("b2b0_valid", m_out_valid, 1);
    check("b2b0_data",  m_out_data, 1);
    send(0, 1);
    check("b2b1_valid", m_out_valid, 1);
    check("b2b1_data",  m_out_data, 0);
    check("b2b1_bits",  m_out_bits, 1);
    tick();

    // in_last on the WIDTH-th bit -> full word with out_last
    for (int i = 0; i < 7; i++) send(0, 0);
    send(1, 1);
    check("fulllast_data", m_out_data, 8'h01);
    check("fulllast_bits", m_out_bits, 8);
    check("fulllast_last", m_out_last, 1);
    check("fulllast_l_data", l_out_data, 8'h80);
    tick();

    // Backpressure: 0xA5 completes, consumer stalls for 5 cycles
    out_ready = 1'b0;
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_bit = 1'b1; #1;
      check("stall_in_ready", m_in_ready, 0);
      check("stall_valid",    m_out_valid, 1);
      check("stall_data",     m_out_data, 8'hA5);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", m_in_ready, 1);
    send_byte(8'h3C);
    check("resume_valid", m_out_valid, 1);
    check("resume_data",  m_out_data, 8'h3C);
    tick();

    // Partial word discarded by reset
    send(1, 0); send(0, 0); send(1, 0); send(0, 0);
    check("partial_no_valid", m_out_valid, 0);
    rst_n = 1'b0; #1;
    check("rst_in_ready_low", m_in_ready, 0);
    tick();
    check("rst2_out_data", m_out_data, 0);
    check("rst2_out_bits", m_out_bits, 0);
    check("rst2_out_valid", m_out_valid, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) send(1, 0);
    check("ff_not_early", m_out_valid, 0);
    send(1, 0);
    check("ff_valid", m_out_valid, 1);
    check("ff_data",  m_out_data, 8'hFF);
    check("ff_bits",  m_out_bits, 8);
    check("ff_l_data", l_out_data, 8'hFF);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
